// File: rtl/lipsi_pkg.sv
// rtl/lipsi_pkg.sv - shared loader state encoding, sync marker and memory map
package lipsi_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEN       = 2'd1,
        DATA      = 2'd2,
        RUN       = 2'd3
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    // Program area is loaded from PROG_BASE; the data area above is left untouched.
    localparam logic [8:0] PROG_BASE = 9'h000;
    localparam logic [8:0] DATA_BASE = 9'h100;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchroniser and stop-bit check
module uart_rx
    import lipsi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP,
        RX_REARM
    } rx_state_t;

    rx_state_t     state;
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            sync1    <= rx;
            sync2    <= sync1;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!sync2) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state   <= sync2 ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_REARM;
                        if (sync2) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_REARM: begin
                    if (sync2) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lipsi_loader.sv
// rtl/lipsi_loader.sv - UART program loader writing a framed image into memory_block
module lipsi_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = lipsi_pkg::SYNC_BYTE,
    parameter int         AW           = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [7:0]    mem_wr_data,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          frame_err
);
    import lipsi_pkg::*;

    loader_state_t state;
    logic [8:0]    remaining;
    logic [AW-1:0] addr;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_SYNC;
            remaining   <= '0;
            addr        <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            cpu_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            frame_err <= rx_err;
            if (rx_err && (state == LEN || state == DATA)) begin
                state     <= WAIT_SYNC;
                busy      <= 1'b0;
                cpu_reset <= 1'b1;
            end else begin
                case (state)
                    WAIT_SYNC: begin
                        cpu_reset <= 1'b1;
                        if (rx_valid && rx_byte == SYNC_BYTE) begin
                            state <= LEN;
                            busy  <= 1'b1;
                        end
                    end
                    LEN: begin
                        if (rx_valid) begin
                            remaining <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                            addr      <= AW'(PROG_BASE);
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        // remaining reaches 0 the cycle the last strobe is out; finish one later.
                        if (remaining == 9'd0) begin
                            state     <= RUN;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else if (rx_valid) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= addr;
                            mem_wr_data <= rx_byte;
                            addr        <= addr + AW'(1);
                            remaining   <= remaining - 9'd1;
                        end
                    end
                    RUN: begin
                        if (rx_valid && rx_byte == SYNC_BYTE) begin
                            state     <= LEN;
                            busy      <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lipsi_loader.sv
// tb/tb_lipsi_loader.sv - randomized self-checking bench for lipsi_loader
module tb_lipsi_loader;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       mem_wr_en;
    logic [8:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       frame_err;

    int checks = 0;
    int fails = 0;

    lipsi_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'h55), .AW(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Observed activity
    logic [16:0] wq[$];
    int  done_cnt, ferr_cnt, dbl, cyc, last_wr_cyc, done_gap;
    logic done_cr, prev_wr;

    always @(negedge clk) begin
        cyc++;
        if (mem_wr_en) begin
            wq.push_back({mem_wr_addr, mem_wr_data});
            last_wr_cyc = cyc;
            if (prev_wr) dbl++;
        end
        prev_wr = mem_wr_en;
        if (done) begin
            done_cnt++;
            done_gap = cyc - last_wr_cyc;
            done_cr  = cpu_reset;
        end
        if (frame_err) ferr_cnt++;
    end

    // Reference model: what a loader should do with a stream of received bytes
    logic [16:0] eq[$];
    bit  have_sync, running;
    int  left, next_addr, exp_done, exp_ferr;

    task automatic model_reset();
        have_sync = 0; running = 0; left = 0; next_addr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_ferr++;
            if (have_sync || left > 0) begin have_sync = 0; left = 0; end
        end else if (left > 0) begin
            eq.push_back({9'(next_addr), b});
            next_addr++;
            left--;
            if (left == 0) begin exp_done++; running = 1; end
        end else if (have_sync) begin
            left = (b == 8'd0) ? 256 : int'(b);
            next_addr = 0;
            have_sync = 0;
        end else if (b == 8'h55) begin
            have_sync = 1;
            running = 0;
        end
    endtask

    task automatic clear_obs();
        wq.delete(); eq.delete();
        done_cnt = 0; ferr_cnt = 0; dbl = 0; exp_done = 0; exp_ferr = 0;
        done_gap = -1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        rx = 1'b0; wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; wait_cyc(CPB); end
        rx = stop; wait_cyc(CPB);
        rx = 1'b1; wait_cyc(4);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b1);
        model_byte(b, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1;
        wait_cyc(3);
        checks++;
        if ({cpu_reset, mem_wr_en, busy, done, frame_err} !== 5'b10000) begin
            $display("FAIL reset_ctrl: got %b want 10000", {cpu_reset, mem_wr_en, busy, done, frame_err}); fails++;
        end
        checks++;
        if ({mem_wr_addr, mem_wr_data} !== 17'd0) begin
            $display("FAIL reset_bus: got %h want 0", {mem_wr_addr, mem_wr_data}); fails++;
        end
        reset = 1'b0;
        model_reset();
        wait_cyc(4);
    endtask

    task automatic test_glitch();
        clear_obs();
        rx = 1'b0; wait_cyc(4);
        rx = 1'b1; wait_cyc(40);
        checks++;
        if (wq.size() != 0 || ferr_cnt != 0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            $display("FAIL glitch: writes %0d ferr %0d busy %b cpu_reset %b want 0 0 0 1", wq.size(), ferr_cnt, busy, cpu_reset); fails++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[5] = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33};
        clear_obs();
        foreach (s[i]) send(s[i]);
        wait_cyc(10);
        checks++;
        if (wq.size() != eq.size()) begin $display("FAIL basic_count: got %0d want %0d", wq.size(), eq.size()); fails++; end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin $display("FAIL basic_write[%0d]: got %h want %h", i, wq[i], eq[i]); fails++; end
        end
        checks++;
        if (done_cnt != exp_done) begin $display("FAIL basic_done: got %0d want %0d", done_cnt, exp_done); fails++; end
        checks++;
        if (done_gap != 1 || done_cr !== 1'b0) begin $display("FAIL basic_done_timing: gap %0d cpu_reset %b want 1 0", done_gap, done_cr); fails++; end
        checks++;
        if (dbl != 0) begin $display("FAIL basic_strobe_width: got %0d double strobes want 0", dbl); fails++; end
        checks++;
        if (cpu_reset !== !running || busy !== 1'b0) begin $display("FAIL basic_final: cpu_reset %b busy %b want %b 0", cpu_reset, busy, !running); fails++; end
    endtask

    task automatic test_reload();
        clear_obs();
        send(8'h55);
        checks++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1) begin $display("FAIL reload_sync: cpu_reset %b busy %b want 1 1", cpu_reset, busy); fails++; end
        send(8'h01); send(8'h42);
        wait_cyc(10);
        checks++;
        if (wq.size() != 1 || eq.size() != 1 || wq[0] !== eq[0]) begin
            $display("FAIL reload_write: got %0d writes first %h want 1 write %h", wq.size(), (wq.size() > 0) ? wq[0] : 17'h0, eq[0]); fails++;
        end
        checks++;
        if (done_cnt != exp_done || cpu_reset !== 1'b0) begin $display("FAIL reload_done: done %0d cpu_reset %b want %0d 0", done_cnt, cpu_reset, exp_done); fails++; end
    endtask

    task automatic test_preamble();
        clear_obs();
        send(8'hAA); send(8'h12);
        checks++;
        if (wq.size() != 0 || cpu_reset !== !running || busy !== 1'b0) begin
            $display("FAIL preamble_ignored: writes %0d cpu_reset %b busy %b want 0 %b 0", wq.size(), cpu_reset, busy, !running); fails++;
        end
        send(8'h55); send(8'h01); send(8'h7E);
        wait_cyc(10);
        checks++;
        if (wq.size() != eq.size()) begin $display("FAIL preamble_count: got %0d want %0d", wq.size(), eq.size()); fails++; end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin $display("FAIL preamble_write[%0d]: got %h want %h", i, wq[i], eq[i]); fails++; end
        end
    endtask

    task automatic test_frame_err();
        clear_obs();
        send(8'h55); send(8'h04); send(8'h01);
        send_bits(8'h77, 1'b0);
        model_byte(8'h77, 1'b0);
        wait_cyc(4);
        checks++;
        if (ferr_cnt != exp_ferr || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            $display("FAIL ferr_abort: ferr %0d busy %b cpu_reset %b want %0d 0 1", ferr_cnt, busy, cpu_reset, exp_ferr); fails++;
        end
        send(8'h55); send(8'h01); send(8'h99);
        wait_cyc(10);
        checks++;
        if (wq.size() != eq.size()) begin $display("FAIL ferr_count: got %0d want %0d", wq.size(), eq.size()); fails++; end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin $display("FAIL ferr_write[%0d]: got %h want %h", i, wq[i], eq[i]); fails++; end
        end
        checks++;
        if (done_cnt != exp_done || cpu_reset !== 1'b0) begin $display("FAIL ferr_done: done %0d cpu_reset %b want %0d 0", done_cnt, cpu_reset, exp_done); fails++; end
    endtask

    task automatic test_full_256();
        int bad;
        clear_obs();
        send(8'h55); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        wait_cyc(10);
        bad = 0;
        for (int i = 0; i < eq.size() && i < wq.size(); i++) if (wq[i] !== eq[i]) bad++;
        checks++;
        if (wq.size() != eq.size() || bad != 0) begin
            $display("FAIL full_writes: got %0d writes %0d wrong want %0d writes", wq.size(), bad, eq.size()); fails++;
        end
        checks++;
        if (wq.size() == 0 || wq[wq.size()-1] !== 17'h0FFFF) begin
            $display("FAIL full_last: got %h want 0ffff", (wq.size() > 0) ? wq[wq.size()-1] : 17'h0); fails++;
        end
        bad = 0;
        foreach (wq[i]) if (wq[i][16:8] >= 9'h100) bad++;
        checks++;
        if (bad != 0) begin $display("FAIL full_data_area: got %0d writes at 0x100+ want 0", bad); fails++; end
        checks++;
        if (done_cnt != 1 || cpu_reset !== 1'b0) begin $display("FAIL full_done: done %0d cpu_reset %b want 1 0", done_cnt, cpu_reset); fails++; end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int n;
        for (int r = 0; r < 3; r++) begin
            clear_obs();
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                do b = 8'($urandom); while (b == 8'h55);
                send(b);
            end
            send(8'h55);
            n = $urandom_range(1, 6);
            send(8'(n));
            for (int k = 0; k < n; k++) send(8'($urandom));
            wait_cyc(10);
            checks++;
            if (wq.size() != eq.size()) begin $display("FAIL rand%0d_count: got %0d want %0d", r, wq.size(), eq.size()); fails++; end
            for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
                checks++;
                if (wq[i] !== eq[i]) begin $display("FAIL rand%0d_write[%0d]: got %h want %h", r, i, wq[i], eq[i]); fails++; end
            end
            checks++;
            if (done_cnt != exp_done || cpu_reset !== !running) begin
                $display("FAIL rand%0d_done: done %0d cpu_reset %b want %0d %b", r, done_cnt, cpu_reset, exp_done, !running); fails++;
            end
        end
    endtask

    task automatic test_reset_mid_load();
        clear_obs();
        send(8'h55); send(8'h04); send(8'h01);
        rx = 1'b0; wait_cyc(CPB);
        rx = 1'b1; wait_cyc(CPB + 10);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cpu_reset, mem_wr_en, busy, done, frame_err} !== 5'b10000 || {mem_wr_addr, mem_wr_data} !== 17'd0) begin
            $display("FAIL midreset_async: ctrl %b bus %h want 10000 0", {cpu_reset, mem_wr_en, busy, done, frame_err}, {mem_wr_addr, mem_wr_data}); fails++;
        end
        rx = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        model_reset();
        wait_cyc(CPB * 12);
        clear_obs();
        send(8'h55); send(8'h02); send(8'hA5); send(8'h5A);
        wait_cyc(10);
        checks++;
        if (wq.size() != eq.size()) begin $display("FAIL midreset_count: got %0d want %0d", wq.size(), eq.size()); fails++; end
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== eq[i]) begin $display("FAIL midreset_write[%0d]: got %h want %h", i, wq[i], eq[i]); fails++; end
        end
        checks++;
        if (done_cnt != exp_done || ferr_cnt != 0 || cpu_reset !== 1'b0) begin
            $display("FAIL midreset_done: done %0d ferr %0d cpu_reset %b want %0d 0 0", done_cnt, ferr_cnt, cpu_reset, exp_done); fails++;
        end
    endtask

    initial begin
        prev_wr = 1'b0; cyc = 0; last_wr_cyc = 0; done_cr = 1'b1;
        clear_obs();
        model_reset();
        test_reset();
        test_glitch();
        test_basic();
        test_reload();
        test_preamble();
        test_frame_err();
        test_full_256();
        test_random();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lipsi_loader.md
Name: lipsi_loader

Overview:
UART program loader: the write-side counterpart of the Lipsi core's memory read path. It receives a framed program image on a serial line and writes it byte-by-byte into memory_block through its write port (write_en/write_addr/write_data). It holds the core in reset while loading and releases it when the image is complete. It sits in top beside memory_block; top muxes its write port with the core's write port, and the loader owns the write port whenever cpu_reset is high.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 8.
SYNC_BYTE, 8'h55, frame start marker.
AW, 9, memory address width; matches the memory_block 512-byte space.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  UART serial input, idle high, 8N1, LSB first; asynchronous to clk
mem_wr_en  output  1  one-cycle write strobe to memory_block
mem_wr_addr  output  AW  write address
mem_wr_data  output  8  write data
cpu_reset  output  1  holds the core (pc, accumulator, fsm) in reset while high
busy  output  1  high in LEN or DATA state
done  output  1  one-cycle pulse after the last byte is written
frame_err  output  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset (async, active high): state=WAIT_SYNC, cpu_reset=1, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, frame_err=0, rx synchroniser flops=1.
- RX path (sub-module):
  - rx goes through a 2-flop synchroniser.
  - Idle until the synchronised rx falls. Count CLKS_PER_BIT/2 cycles (integer division) and resample. If rx is high, it is a false start; return to idle.
  - Sample 8 data bits, each CLKS_PER_BIT cycles apart, LSB first.
  - Sample the stop bit one CLKS_PER_BIT later.
  - Stop=1: pulse rx_valid for 1 cycle with rx_byte.
  - Stop=0: pulse rx_err for 1 cycle, no rx_valid.
  - Then wait for rx high before re-arming.
- Loader FSM, states WAIT_SYNC, LEN, DATA, RUN:
  - WAIT_SYNC: cpu_reset=1. rx_valid with byte==SYNC_BYTE goes to LEN; any other byte is ignored.
  - LEN: on rx_valid, latch remaining = byte, with 0 meaning 256 (9-bit counter). Clear addr to 0 and go to DATA.
  - DATA: on each rx_valid, in the next cycle mem_wr_en=1, mem_wr_addr=addr, mem_wr_data=byte. Then addr increments and remaining decrements. On the cycle the final write is issued, done pulses in the following cycle and the state goes to RUN.
  - RUN: cpu_reset=0; the loader never drives mem_wr_en.
  - RUN, rx_valid with SYNC_BYTE: go to LEN with cpu_reset=1 from the next cycle (reload). Other bytes are ignored.
- Latency: the write strobe is exactly 1 cycle after rx_valid. At most one write per received byte.
- Address range: 0x000..0x0FF (program area; the data area 0x100+ is never written). addr is AW bits; with len 256 the last write is at 0x0FF. No wrap beyond.
- frame_err (any state): pulse frame_err. If in LEN or DATA, abort to WAIT_SYNC with cpu_reset held 1; partial writes are not rolled back. In RUN, the error is ignored apart from the pulse.
- Reset mid-load: all state is cleared immediately, and a receive in progress is discarded.
- Simultaneous events: rx_valid and rx_err are mutually exclusive by construction. reset dominates everything.
- busy = (state==LEN || state==DATA).

Decomposition:
- Shared package lipsi_pkg holds:
  - the loader state encoding (2-bit localparams WAIT_SYNC=0, LEN=1, DATA=2, RUN=3);
  - SYNC_BYTE;
  - the memory map constants PROG_BASE=9'h000 and DATA_BASE=9'h100, which the core's r-path also uses.
- One sub-module, uart_rx (parameter CLKS_PER_BIT; ports clk, reset, rx, rx_byte[7:0], rx_valid, rx_err), contains the synchroniser and bit-timing counter.
- The FSM, address counter and write register live in lipsi_loader.

Test Plan:
All scenarios run with CLKS_PER_BIT=16.
- Reset, then frames 55, 03, 11, 22, 33 -> three single-cycle writes (000:11), (001:22), (002:33); done pulses once; cpu_reset falls with done; busy low afterwards.
- Frames 55, 00, then 256 bytes i=0..255 -> 256 writes, last at addr 0x0FF with data FF; no write to 0x100; cpu_reset deasserts.
- Bytes AA, 12 before 55, 01, 7E -> only one write (000:7E); the leading bytes produce no write and no state change.
- 55, 04, 01, then a frame with stop bit 0 -> frame_err pulse; state WAIT_SYNC; cpu_reset stays 1; only (000:01) is written. A following 55, 01, 99 writes (000:99).
- A glitch on rx low for 4 cycles in WAIT_SYNC -> no rx_valid, no frame_err. Reset asserted mid-byte during DATA -> all outputs return to reset values asynchronously; next full frame loads correctly.
- In RUN, send 55, 01, 42 -> cpu_reset rises the cycle after the sync byte, write (000:42), done, cpu_reset falls.
